// File: rtl/mc_controller.sv
// Multi-cycle control unit for the MIPS-subset CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port and ALU,
// drives every datapath enable/mux select, and counts retired instructions.
module mc_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active-low
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             ext_op,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             retired,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0101;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Instruction decode: only opcode and funct steer the controller.
  logic [5:0] opcode, funct;
  logic       is_addu, is_subu, is_jr, is_ori, is_lui, is_addiu;
  logic       is_lw, is_sw, is_beq, is_j, is_jal;
  logic       is_r_alu, is_i_alu, needs_exec;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  assign is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
  assign is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_addiu = (opcode == OP_ADDIU);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);

  assign is_r_alu   = is_addu | is_subu;
  assign is_i_alu   = is_ori | is_lui | is_addiu;
  assign needs_exec = is_r_alu | is_i_alu | is_lw | is_sw | is_beq;

  // Next-state and control outputs from state, decoded instruction, mem_ready and zero.
  always_comb begin
    // NOTE: every output gets a default up front so no branch can leave one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    reg_write = 1'b0;
    reg_dst   = 2'd0;
    wd_sel    = 2'd0;
    ext_op    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    retired   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_j || is_jal) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          retired  = 1'b1;
          state_d  = S_FETCH;
          if (is_jal) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            wd_sel    = 2'd2;
          end
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
          retired  = 1'b1;
          state_d  = S_FETCH;
        end else if (needs_exec) begin
          state_d = S_EXEC;
        end else begin
          // nop and every unsupported encoding retire without side effects
          retired = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        if (is_addu) begin
          alu_op  = ALU_ADD;
          state_d = S_WB;
        end else if (is_subu) begin
          alu_op  = ALU_SUB;
          state_d = S_WB;
        end else if (is_ori || is_lui) begin
          alu_op    = is_ori ? ALU_OR : ALU_LUI;
          alu_src_b = 1'b1;
          state_d   = S_WB;
        end else if (is_addiu || is_lw || is_sw) begin
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
          ext_op    = 1'b1;
          state_d   = is_addiu ? S_WB : S_MEM;
        end else if (is_beq) begin
          alu_op   = ALU_SUB;
          ext_op   = 1'b1;
          pc_src   = 2'd1;
          pc_write = zero;
          retired  = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            retired = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
        state_d   = S_FETCH;
        if (is_lw) begin
          reg_dst = 2'd1;
          wd_sel  = 2'd1;
        end else if (!is_r_alu) begin
          reg_dst = 2'd1;
        end
      end

      default: state_d = S_FETCH;
    endcase

    // Reset silences the whole control bus, memory request included.
    if (!reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      i_or_d    = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      reg_write = 1'b0;
      reg_dst   = 2'd0;
      wd_sel    = 2'd0;
      ext_op    = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      retired   = 1'b0;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (retired) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples its next value from the same pre-edge snapshot.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random
// instruction streams with random memory stalls, compared cycle by cycle
// against a per-instruction phase model built from the ISA rules.
module tb_mc_controller;

  localparam int CNT_W = 4;

  logic             clk, reset, zero, mem_ready;
  logic [31:0]      instr;
  logic             mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write;
  logic [1:0]       pc_src, reg_dst, wd_sel;
  logic             reg_write, ext_op, alu_src_b, retired;
  logic [3:0]       alu_op;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       state;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, wd_sel;
    logic       ext_op, alu_src_b;
    logic [3:0] alu_op;
    logic       retired;
    logic [2:0] state;
  } ctl_t;

  typedef enum {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_ADDIU, C_LW, C_SW,
                C_BEQ, C_J, C_JAL, C_NOP} cls_e;

  ctl_t act;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_m    = 0;

  assign act = {mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write, pc_src,
                reg_write, reg_dst, wd_sel, ext_op, alu_src_b, alu_op, retired, state};

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .wd_sel(wd_sel), .ext_op(ext_op),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .retired(retired),
    .instr_count(instr_count), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cls_e classify(input logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h21) return C_ADDU;
      if (fn == 6'h23) return C_SUBU;
      if (fn == 6'h08) return C_JR;
      return C_NOP;
    end
    case (op)
      6'h0D: return C_ORI;
      6'h0F: return C_LUI;
      6'h09: return C_ADDIU;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_NOP;
    endcase
  endfunction

  // Called at posedge+1 with inputs already driven; checks, then advances one cycle.
  task automatic cyc(input ctl_t e, input string tag);
    #1;
    check({tag, "/ctl"}, 32'(act), 32'(e));
    check({tag, "/cnt"}, 32'(instr_count), 32'(cnt_m % (1 << CNT_W)));
    @(posedge clk);
    #1;
    if (e.retired) cnt_m++;
  endtask

  task automatic do_instr(input string nm, input logic [31:0] ins, input logic z,
                          input int fs, input int ms);
    cls_e c;
    ctl_t e;
    int   k;
    c = classify(ins);
    instr = ins;
    k = 0;
    // FETCH: stalled cycles request only, ready cycle loads IR and PC+4
    for (int i = 0; i < fs; i++) begin
      mem_ready = 1'b0; zero = 1'($urandom);
      e = '0; e.mem_req = 1'b1;
      cyc(e, $sformatf("%s c%0d", nm, k++));
    end
    mem_ready = 1'b1; zero = 1'($urandom);
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(e, $sformatf("%s c%0d", nm, k++));
    // DECODE
    mem_ready = 1'($urandom); zero = 1'($urandom);
    e = '0; e.state = 3'd1;
    case (c)
      C_J:   begin e.pc_write = 1'b1; e.pc_src = 2'd2; e.retired = 1'b1; end
      C_JAL: begin
        e.pc_write = 1'b1; e.pc_src = 2'd2; e.retired = 1'b1;
        e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
      end
      C_JR:  begin e.pc_write = 1'b1; e.pc_src = 2'd3; e.retired = 1'b1; end
      C_NOP: e.retired = 1'b1;
      default: ;
    endcase
    cyc(e, $sformatf("%s c%0d", nm, k++));
    if (c inside {C_J, C_JAL, C_JR, C_NOP}) return;
    // EXEC
    mem_ready = 1'($urandom); zero = z;
    e = '0; e.state = 3'd2;
    case (c)
      C_ADDU:  e.alu_op = 4'b0000;
      C_SUBU:  e.alu_op = 4'b0001;
      C_ORI:   begin e.alu_op = 4'b0011; e.alu_src_b = 1'b1; end
      C_LUI:   begin e.alu_op = 4'b0101; e.alu_src_b = 1'b1; end
      C_BEQ:   begin
        e.alu_op = 4'b0001; e.ext_op = 1'b1; e.pc_src = 2'd1;
        e.pc_write = z; e.retired = 1'b1;
      end
      default: begin e.alu_op = 4'b0000; e.alu_src_b = 1'b1; e.ext_op = 1'b1; end
    endcase
    cyc(e, $sformatf("%s c%0d", nm, k++));
    if (c == C_BEQ) return;
    // MEM
    if (c inside {C_LW, C_SW}) begin
      for (int i = 0; i < ms; i++) begin
        mem_ready = 1'b0; zero = 1'($urandom);
        e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = (c == C_SW);
        cyc(e, $sformatf("%s c%0d", nm, k++));
      end
      mem_ready = 1'b1; zero = 1'($urandom);
      e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = (c == C_SW);
      if (c == C_SW) e.retired = 1'b1;
      else           e.mdr_write = 1'b1;
      cyc(e, $sformatf("%s c%0d", nm, k++));
      if (c == C_SW) return;
    end
    // WB
    mem_ready = 1'($urandom); zero = 1'($urandom);
    e = '0; e.state = 3'd4; e.reg_write = 1'b1; e.retired = 1'b1;
    if (c == C_LW) begin e.reg_dst = 2'd1; e.wd_sel = 2'd1; end
    else if (c inside {C_ORI, C_LUI, C_ADDIU}) e.reg_dst = 2'd1;
    cyc(e, $sformatf("%s c%0d", nm, k++));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    case ($urandom_range(0, 12))
      0:  return {6'h00, rs, rt, rd, 5'h00, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'h00, 6'h23};
      2:  return {6'h00, rs, 15'h0000, 6'h08};
      3:  return {6'h0D, rs, rt, imm};
      4:  return {6'h0F, 5'h00, rt, imm};
      5:  return {6'h09, rs, rt, imm};
      6:  return {6'h23, rs, rt, imm};
      7:  return {6'h2B, rs, rt, imm};
      8:  return {6'h04, rs, rt, imm};
      9:  return {6'h02, tgt};
      10: return {6'h03, tgt};
      11: return {6'h38 | 6'($urandom_range(0, 7)), tgt};
      default: return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endcase
  endfunction

  initial begin
    ctl_t e;
    int   start;
    reset = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;

    // Outputs held at zero during reset even with mem_ready high
    #3;
    check("reset_ctl", 32'(act), 32'h0);
    check("reset_cnt", 32'(instr_count), 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    e = '0; e.mem_req = 1'b1;
    check("first_fetch", 32'(act), 32'(e));
    @(posedge clk);
    #1;

    do_instr("addu", 32'h00221821, 1'b0, 0, 0);
    do_instr("lw", 32'h8C040008, 1'b0, 0, 2);
    do_instr("beq_z1", 32'h10220005, 1'b1, 0, 0);
    do_instr("beq_z0", 32'h10220005, 1'b0, 0, 0);
    do_instr("jal", 32'h0C000300, 1'b0, 0, 0);
    do_instr("jr", 32'h03E00008, 1'b0, 0, 0);
    do_instr("unknown", 32'hFC000000, 1'b0, 0, 0);
    do_instr("sw_stall", 32'hAC050004, 1'b0, 2, 1);

    start = cnt_m;
    for (int i = 0; i < 16; i++) do_instr($sformatf("nop%0d", i), 32'h0, 1'b0, 0, 0);
    check("nop_wrap", 32'(instr_count), 32'(start % (1 << CNT_W)));

    // Reset asserted mid-MEM of a stalled lw
    instr = 32'h8C040008;
    mem_ready = 1'b1;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(e, "rlw c0");
    e = '0; e.state = 3'd1;
    cyc(e, "rlw c1");
    e = '0; e.state = 3'd2; e.alu_src_b = 1'b1; e.ext_op = 1'b1;
    cyc(e, "rlw c2");
    mem_ready = 1'b0;
    e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.i_or_d = 1'b1;
    cyc(e, "rlw c3");
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_ctl", 32'(act), 32'h0);
    check("rst_mid_cnt", 32'(instr_count), 32'h0);
    mem_ready = 1'b1;
    #1;
    check("rst_ready_ctl", 32'(act), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_ctl", 32'(act), 32'h0);
    check("rst_hold_cnt", 32'(instr_count), 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cnt_m = 0;
    #1;
    e = '0; e.mem_req = 1'b1;
    check("rst_release_fetch", 32'(act), 32'(e));
    @(posedge clk);
    #1;

    // Random instruction stream with random stalls
    for (int i = 0; i < 80; i++)
      do_instr($sformatf("rnd%0d", i), rand_instr(), 1'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control unit for the team's MIPS-subset CPU. It replaces the single-cycle decoder so that one unified memory port and one ALU can be shared across the cycles of each instruction.
- It sequences FETCH/DECODE/EXEC/MEM/WB, drives all datapath enables and muxes, and handshakes with the memory port.
- Supported set: addu, subu, ori, lui, addiu, lw, sw, beq, j, jal, jr. Every other encoding executes as nop.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset: reset=0 resets.
instr  input  32  current IR contents; valid from DECODE onward.
zero  input  1  ALU zero flag, valid in EXEC.
mem_ready  input  1  memory completes the pending request this cycle.
mem_req  output  1  memory access request.
mem_we  output  1  store when 1, load when 0; meaningful only with mem_req.
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
ir_write  output  1  load IR from memory data.
mdr_write  output  1  load MDR from memory data.
pc_write  output  1  PC update enable.
pc_src  output  2  PC source: 0=PC+4, 1=branch target, 2=jump target, 3=register A (jr).
reg_write  output  1  regfile write enable.
reg_dst  output  2  write address: 0=rd, 1=rt, 2=$31.
wd_sel  output  2  write data: 0=ALUOut, 1=MDR, 2=PC (already PC+4).
ext_op  output  1  immediate extension: 1=sign, 0=zero.
alu_src_b  output  1  ALU B input: 0=register B, 1=extended immediate.
alu_op  output  4  ALU opcode: 0000 add, 0001 sub, 0011 or, 0101 lui.
retired  output  1  one-cycle pulse when an instruction completes.
instr_count  output  CNT_W  number of retired instructions.
state  output  3  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 are illegal and go to FETCH on the next edge.
- Decoding:
  - opcode=instr[31:26]; funct=instr[5:0] when opcode=0.
  - addu funct 100001, subu 100011, jr 001000.
  - ori 001101, lw 100011, sw 101011, lui 001111, beq 000100, jal 000011, addiu 001001, j 000010.
- Output logic is combinational Moore/Mealy from state, decoded instr, mem_ready and zero. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, i_or_d=0, mem_we=0.
  - While mem_ready=0: hold in FETCH with no other enables.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE (register A/B capture is free-running in the datapath):
  - j: pc_write=1, pc_src=2. Retire, go to FETCH.
  - jal: as j, plus reg_write=1, reg_dst=2, wd_sel=2. Retire, go to FETCH.
  - jr: pc_write=1, pc_src=3. Retire, go to FETCH.
  - nop or unknown: retire, go to FETCH.
  - All others: go to EXEC.
- EXEC:
  - addu: alu_op=0000, alu_src_b=0. Go to WB.
  - subu: alu_op=0001, alu_src_b=0. Go to WB.
  - ori: alu_op=0011, alu_src_b=1, ext_op=0. Go to WB.
  - lui: alu_op=0101, alu_src_b=1, ext_op=0. Go to WB.
  - addiu: alu_op=0000, alu_src_b=1, ext_op=1. Go to WB.
  - lw/sw: alu_op=0000, alu_src_b=1, ext_op=1. Go to MEM.
  - beq: alu_op=0001, alu_src_b=0, ext_op=1, pc_src=1, pc_write=zero. Retire, go to FETCH.
- MEM:
  - mem_req=1, i_or_d=1, mem_we=1 for sw and 0 for lw. Hold while mem_ready=0.
  - On mem_ready=1, sw: retire, go to FETCH.
  - On mem_ready=1, lw: mdr_write=1, go to WB.
- WB:
  - reg_write=1.
  - lw: reg_dst=1, wd_sel=1.
  - R-type: reg_dst=0, wd_sel=0.
  - I-type ALU: reg_dst=1, wd_sel=0.
  - Retire, go to FETCH.
- Retire: retired=1 in the retiring cycle; instr_count increments on that clock edge and wraps modulo 2^CNT_W.
- Latency with mem_ready tied high, in cycles:
  - j/jal/jr/nop: 2.
  - beq: 3.
  - ALU ops and sw: 4.
  - lw: 5.
- Every mem_ready wait cycle in FETCH or MEM adds one cycle. mem_ready outside FETCH/MEM is ignored.
- Reset:
  - reset=0 at any time, including mid-instruction or mid-handshake, immediately sets state=FETCH and instr_count=0.
  - All outputs are forced to 0 while reset=0, including mem_req.
  - The first fetch request appears in the first cycle after reset deasserts.
- Register write of $0: the controller still asserts reg_write; the regfile ignores it.

Test Plan:
- Reset mid-MEM of a stalled lw (mem_ready=0), then release reset -> state=0 and instr_count=0 immediately; no reg_write or mdr_write ever pulses; mem_req=1 with i_or_d=0 next cycle.
- addu $3,$1,$2 (0x00221821), mem_ready=1 -> states 0,1,2,4. EXEC alu_op=0000, alu_src_b=0. WB reg_write=1, reg_dst=0, wd_sel=0. retired in cycle 4; instr_count 0->1.
- lw $4,8($0) (0x8C040008) with mem_ready low 2 cycles in MEM -> MEM held 3 cycles. mdr_write only on the ready cycle. WB reg_dst=1, wd_sel=1. Total 7 cycles.
- beq with zero=1, then beq with zero=0 -> pc_write=1 with pc_src=1 in EXEC for the first; pc_write=0 for the second. Both retire in 3 cycles.
- jal 0x0000C00 (0x0C000300) -> DECODE: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wd_sel=2. Completes in 2 cycles. jr $31 (0x03E00008) -> pc_src=3.
- Unknown opcode 0xFC000000, and CNT_W=4 running 16 nops -> unknown opcode retires in 2 cycles with no writes; nop run shows instr_count wrapping 15->0.
